// File: rtl/reg_file_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_file_param                                                   |
// | Purpose : WIDTH x DEPTH register file, two combinational read ports, one   |
// |           write port, optional zero register, reset-driven clear sweep.    |
// |           Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module reg_file_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             ready
);

    localparam logic [0:0]    c_st_clear = 1'b0;
    localparam logic [0:0]    c_st_run   = 1'b1;
    localparam logic [AW-1:0] c_last     = AW'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_wa;
    logic [WIDTH-1:0] w_mem_wd;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_clear;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // The sweep and normal writes share one write port so storage maps onto
    // a simple one-write-per-cycle array.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        w_mem_wa    = wa;
        w_mem_wd    = wd;
        case (r_state)
            c_st_clear: begin
                w_mem_we  = 1'b1;
                w_mem_wa  = r_ptr;
                w_mem_wd  = '0;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_last) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                w_mem_we = we && in_range(wa) && !is_zero_reg(wa);
            end
            default: begin
                w_state_nxt = c_st_clear;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    logic [AW-1:0]    w_ra [2];
    logic [WIDTH-1:0] w_rd [2];

    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                w_rd[gi] = '0;
                if (r_state == c_st_run && in_range(w_ra[gi]) && !is_zero_reg(w_ra[gi])) begin
                    w_rd[gi] = r_mem[w_ra[gi]];
`ifdef REGFILE_BYPASS_EN
                    // In RUN, w_mem_we already excludes out-of-range and zero-register writes.
                    if (w_mem_we && (w_mem_wa == w_ra[gi])) begin
                        w_rd[gi] = wd;
                    end
`else
`endif
                end
            end
        end
    endgenerate

    assign rd1   = w_rd[0];
    assign rd2   = w_rd[1];
    assign ready = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_reg_file_param                                                |
// | Purpose : Self-checking bench: 32x32 zero-reg file and 20-deep plain file  |
// |           against an array model, directed plus random stimulus.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        ready_a, ready_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_a [32];
    logic [31:0] m_b [20];
    int          m_cnt;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a), .ready(ready_a)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .ready(ready_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Expected read for a register file of the given depth, taken from the
    // rules: not ready -> 0, out of range -> 0, zero register -> 0, bypass, array.
    function automatic logic [31:0] exp_rd(input int depth, input bit zr, input logic [4:0] ra);
        logic [31:0] v;
        v = 32'h0;
        if (m_cnt >= depth && int'(ra) < depth && !(zr && ra == 5'd0)) begin
            if (c_byp && we && wa == ra) v = wd;
            else if (depth == 32) v = m_a[ra];
            else v = m_b[ra];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_a[i] = 32'h0;
        for (int i = 0; i < 20; i++) m_b[i] = 32'h0;
    endtask

    // Check outputs mid-cycle, then advance one edge and update the model.
    task automatic cycle();
        @(negedge clk);
        check("ready_a", {31'h0, ready_a}, {31'h0, (m_cnt >= 32)});
        check("ready_b", {31'h0, ready_b}, {31'h0, (m_cnt >= 20)});
        check("rd1_a", rd1_a, exp_rd(32, 1'b1, ra1));
        check("rd2_a", rd2_a, exp_rd(32, 1'b1, ra2));
        check("rd1_b", rd1_b, exp_rd(20, 1'b0, ra1));
        check("rd2_b", rd2_b, exp_rd(20, 1'b0, ra2));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_cnt >= 32 && we && wa != 5'd0) m_a[wa] = wd;
            if (m_cnt >= 20 && we && wa < 5'd20) m_b[wa] = wd;
            if (m_cnt < 1000) m_cnt++;
        end
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        cycle();
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset held, with write attempts that must be dropped
        for (int i = 0; i < 3; i++) drive(1'b1, 5'(i + 1), 32'hFFFF_0000, 5'(i + 1), 5'd0);
        rst = 1'b0;
        // Sweep with we asserted throughout
        for (int i = 0; i < 34; i++) drive(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
        // Every register reads back zero
        for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        // Basic write/read
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd31);
        drive(1'b1, 5'd31, 32'h1234_5678, 5'd5, 5'd31);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        // Register 0 write
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        // Out-of-range write for the 20-deep file
        drive(1'b1, 5'd25, 32'hCAFE_F00D, 5'd25, 5'd5);
        drive(1'b0, 5'd0, 32'h0, 5'd25, 5'd5);
        // Same-cycle write and read of one address
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        rand_cycles(300);
        // Reset mid-operation
        drive(1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        rst = 1'b0;
        for (int i = 0; i < 34; i++) drive(1'b1, 5'd3, 32'h77, 5'd3, 5'($urandom_range(0, 31)));
        rand_cycles(200);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-read, single-write register file for the single-cycle and pipelined datapaths; the successor to the fixed 32x32 register file. It adds configurable width and depth, an optional hardwired zero register, and a reset-driven clear sweep with a `ready` indication, so storage can map onto single-port-per-cycle arrays. A compile-time option enables write-to-read bypass for pipelined cores.

## Interface

Parameters:
- `WIDTH`, 32: data width in bits (≥1).
- `DEPTH`, 32: number of registers (≥2; need not be a power of two).
- `ZERO_REG`, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.
- Derived localparam `AW` = `$clog2(DEPTH)`: address width.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `we`  in  1: write enable.
- `wa`  in  AW: write address.
- `wd`  in  WIDTH: write data.
- `ra1`  in  AW: read address, port 1.
- `ra2`  in  AW: read address, port 2.
- `rd1`  out  WIDTH: read data, port 1 (combinational).
- `rd2`  out  WIDTH: read data, port 2 (combinational).
- `ready`  out  1: high when the clear sweep is complete and the file accepts writes.

## Operation

- **States:**
  - `CLEAR`: sweeping; `ready`=0.
  - `RUN`: normal operation; `ready`=1.
- **Reset:** at any posedge with `rst`=1:
  - state ← `CLEAR`, sweep pointer `ptr` ← 0, `ready` ← 0.
  - All writes are dropped.
  - Reset value of `ready` is 0.
  - `rd1`/`rd2` read 0 while in `CLEAR`.
- **`CLEAR` (rst=0):** each posedge does `mem[ptr]` ← 0 and `ptr` ← `ptr`+1.
  - When `ptr`==DEPTH-1, the next state is `RUN` and `ready` ← 1 on that same edge.
  - `we` is ignored throughout `CLEAR`.
- **`RUN`:** at a posedge with `we`=1 and `wa` < DEPTH, `mem[wa]` ← `wd`.
  - If `ZERO_REG`=1 and `wa`==0, the write is dropped.
- **Reads:** `rdN` = `mem[raN]`, combinational.
  - `raN` ≥ DEPTH → 0.
  - `ZERO_REG`=1 and `raN`==0 → 0.
  - In `CLEAR` → 0.
- Both read ports are fully independent and may address the same register.
- **Out-of-range write** (`wa` ≥ DEPTH): ignored, no state change.
- **Reset mid-sweep or mid-operation:** the sweep restarts from `ptr`=0. Contents are eventually fully zeroed regardless of prior state.

## Timing

- Write latency: data is visible on `rdN` in the cycle after the write edge (without bypass).
- Read latency: 0 cycles, combinational from `raN` and storage.
- Sweep length: `ready` rises on the DEPTH-th rising edge after the first edge with `rst`=0. For DEPTH=32, that is the 32nd edge.
- Holding `rst` high keeps `ptr` at 0 and `ready` at 0 indefinitely.
- Same-edge write and read of one address: the read returns the old value until the edge, unless bypass is compiled in.

## Configuration

- Macro `REGFILE_BYPASS_EN`.
  - **Defined:** in `RUN`, if `we`=1, `wa`==`raN`, `wa` < DEPTH, and the write is not to a suppressed zero register, then `rdN` = `wd` combinationally in the same cycle. Each port is bypassed independently.
  - **Undefined:** no forwarding. `rdN` always reflects stored contents (or 0 per the rules above).
  - Bypass is never active in `CLEAR`.

## Test plan

- **Reset sweep:** DEPTH=32. Hold `rst` 3 cycles, then release.
  - `ready`=0 for 31 edges and goes 1 on the 32nd.
  - All 32 registers then read 0.
  - `we`=1 during the sweep writes nothing.
- **Basic write/read:** write 0xDEADBEEF to reg 5 and 0x12345678 to reg 31.
  - Next cycle, `ra1`=5 → 0xDEADBEEF and `ra2`=31 → 0x12345678.
  - `ra1`=`ra2`=5 → both 0xDEADBEEF.
- **Zero register:** `ZERO_REG`=1, write 0xFFFFFFFF to reg 0 → `rd1` reads 0.
  - Rebuild with `ZERO_REG`=0 → reads 0xFFFFFFFF.
- **Non-power-of-two depth:** DEPTH=20, AW=5.
  - Write to addr 25 → no register changes.
  - `ra1`=25 → 0.
  - Sweep completes in 20 edges.
- **Bypass:** with `REGFILE_BYPASS_EN`, `we`=1, `wa`=7, `wd`=0xA5A5A5A5, `ra1`=7.
  - `rd1`=0xA5A5A5A5 in the same cycle.
  - Without the macro, `rd1` shows the old value until after the edge.
- **Reset mid-operation:** write 0x55 to reg 3, then pulse `rst` for 1 cycle.
  - `ready` drops immediately.
  - Reg 3 reads 0 after the sweep completes.
  - `ready` returns DEPTH edges after reset release.
